// File: rtl/seq_datapath.sv
// Self-sequenced arithmetic unit: start/busy/done handshake over NEG, MUL10, DUP, ABS and MULC.
// Define SEQ_DATAPATH_MULC_EN to build the W-cycle shift-add multiply (op 011); otherwise op 011 is illegal.
module seq_datapath #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic [2:0]   op_i,
   input  logic [W-1:0] data_i,
   input  logic [W-1:0] coef_i,
   output logic [W-1:0] out_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic         co_o,
   output logic         ovf_o,
   output logic         z_o,
   output logic         n_o
);

   localparam int CW = $clog2(W + 1);
   localparam logic [2:0] OP_NEG   = 3'b000;
   localparam logic [2:0] OP_MUL10 = 3'b001;
   localparam logic [2:0] OP_DUP   = 3'b010;
   localparam logic [2:0] OP_MULC  = 3'b011;
   localparam logic [2:0] OP_ABS   = 3'b100;
   localparam logic [W-1:0]   MIN_NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [2*W-1:0] ONE     = {{(2*W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic [W-1:0]   a_q, a_d;
   logic [2*W-1:0] work_q, work_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   out_q, out_d;
   logic           co_q, co_d, ovf_q, ovf_d, z_q, z_d, n_q, n_d, err_q, err_d;
   logic [CW-1:0]  lastStep;
   logic           legal;
   logic           negate;
   logic [W+3:0]   aExt, mul10S;
   logic           mul10Ovf;

`ifdef SEQ_DATAPATH_MULC_EN
   logic [2*W-1:0] mcand_q, mcand_d;
   logic [W-1:0]   coefSr_q, coefSr_d;
`else
   logic           coef_unused;
   assign coef_unused = ^coef_i;
`endif

   // ABS of a negative operand runs exactly the NEG sequence, flags included.
   assign negate   = (op_q == OP_NEG) || ((op_q == OP_ABS) && a_q[W-1]);
   assign aExt     = {{4{a_q[W-1]}}, a_q};
   assign mul10S   = (aExt << 3) + (aExt << 1);
   assign mul10Ovf = !((&mul10S[W+3:W-1]) || !(|mul10S[W+3:W-1]));

   always_comb begin
      legal    = 1'b1;
      lastStep = CW'(1);
      case (op_q)
         OP_NEG, OP_MUL10, OP_ABS: lastStep = CW'(1);
         OP_DUP:                   lastStep = CW'(2);
`ifdef SEQ_DATAPATH_MULC_EN
         OP_MULC:                  lastStep = CW'(W - 1);
`endif
         default: begin
            legal    = 1'b0;
            lastStep = '0;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      z_d     = z_q;
      n_d     = n_q;
      err_d   = 1'b0;
`ifdef SEQ_DATAPATH_MULC_EN
      mcand_d  = mcand_q;
      coefSr_d = coefSr_q;
`endif
      case (state_q)
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            case (op_q)
               OP_NEG, OP_ABS: begin
                  if (!negate)
                     work_d = {{W{1'b0}}, a_q};
                  else if (cnt_q == '0)
                     work_d = {{W{1'b0}}, ~a_q};
                  else
                     work_d = work_q + ONE;
               end
               OP_MUL10: begin
                  if (cnt_q == '0)
                     work_d = {{W{1'b0}}, a_q} << 3;
                  else
                     work_d = work_q + ({{W{1'b0}}, a_q} << 1);
               end
               OP_DUP: begin
                  if (cnt_q == '0)
                     work_d = {{W{1'b0}}, a_q >> (W/2)};
                  else if (cnt_q == CW'(1))
                     work_d = {{W{1'b0}}, work_q[W-1:0] << (W/2)};
                  else
                     work_d = work_q | {{W{1'b0}}, a_q >> (W/2)};
               end
`ifdef SEQ_DATAPATH_MULC_EN
               OP_MULC: begin
                  if (coefSr_q[0])
                     work_d = work_q + mcand_q;
                  mcand_d  = mcand_q << 1;
                  coefSr_d = coefSr_q >> 1;
               end
`endif
               default: ;
            endcase
            // Result and flags are published only on the transition into DONE.
            if (cnt_q == lastStep) begin
               state_d = DONE;
               if (legal) begin
                  out_d = work_d[W-1:0];
                  z_d   = (work_d[W-1:0] == '0);
                  n_d   = work_d[W-1];
                  co_d  = 1'b0;
                  ovf_d = 1'b0;
                  case (op_q)
                     OP_NEG, OP_ABS: begin
                        if (negate) begin
                           co_d  = work_d[W];
                           ovf_d = (a_q == MIN_NEG);
                        end
                     end
                     OP_MUL10: begin
                        co_d  = |work_d[2*W-1:W];
                        ovf_d = mul10Ovf;
                     end
                     OP_MULC: co_d = |work_d[2*W-1:W];
                     default: ;
                  endcase
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            if (start_i) begin
               state_d = RUN;
               op_d    = op_i;
               a_d     = data_i;
               work_d  = '0;
               cnt_d   = '0;
`ifdef SEQ_DATAPATH_MULC_EN
               mcand_d  = {{W{1'b0}}, data_i};
               coefSr_d = coef_i;
`endif
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         err_q   <= 1'b0;
`ifdef SEQ_DATAPATH_MULC_EN
         mcand_q  <= '0;
         coefSr_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         z_q     <= z_d;
         n_q     <= n_d;
         err_q   <= err_d;
`ifdef SEQ_DATAPATH_MULC_EN
         mcand_q  <= mcand_d;
         coefSr_q <= coefSr_d;
`endif
      end
   end

   assign out_o  = out_q;
   assign busy_o = (state_q == RUN);
   assign done_o = (state_q == DONE);
   assign err_o  = err_q;
   assign co_o   = co_q;
   assign ovf_o  = ovf_q;
   assign z_o    = z_q;
   assign n_o    = n_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboard bench for seq_datapath: directed cases plus random ops against an arithmetic reference model.
// Follows SEQ_DATAPATH_MULC_EN so op 011 is modelled as MULC or as an illegal op.
module tb_seq_datapath;

   localparam int W    = 8;
   localparam int MOD  = 1 << W;
   localparam int HALF = 1 << (W - 1);

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         start_i;
   logic [2:0]   op_i;
   logic [W-1:0] data_i;
   logic [W-1:0] coef_i;
   logic [W-1:0] out_o;
   logic         busy_o, done_o, err_o, co_o, ovf_o, z_o, n_o;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] out;
      bit           co, ovf, z, n, err;
      int           doneCyc;
   } exp_t;

   exp_t         expQ[$];
   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   logic [W-1:0] mOut;
   bit           mCo, mOvf, mZ, mN;

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   seq_datapath #(.W(W)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .start_i (start_i),
      .op_i    (op_i),
      .data_i  (data_i),
      .coef_i  (coef_i),
      .out_o   (out_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .err_o   (err_o),
      .co_o    (co_o),
      .ovf_o   (ovf_o),
      .z_o     (z_o),
      .n_o     (n_o)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: results from plain integer arithmetic on the operation definitions.
   task automatic computeExpect(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output exp_t e, output int lat);
      int     aU, aS, bU, res, hi;
      longint p;
      bit     legal, co, ovf;
      aU = int'(a);
      bU = int'(b);
      aS = a[W-1] ? aU - MOD : aU;
      legal = 1'b1;
      co  = 1'b0;
      ovf = 1'b0;
      res = 0;
      lat = 1;
      case (op)
         3'd0: begin
            res = (MOD - aU) % MOD;
            co  = (aU == 0);
            ovf = (aU == HALF);
            lat = 2;
         end
         3'd1: begin
            res = (10 * aU) % MOD;
            co  = (10 * aU) >= MOD;
            ovf = (10 * aS < -HALF) || (10 * aS > HALF - 1);
            lat = 2;
         end
         3'd2: begin
            hi  = aU / (1 << (W / 2));
            res = hi * (1 << (W / 2)) + hi;
            lat = 3;
         end
         3'd3: begin
`ifdef SEQ_DATAPATH_MULC_EN
            p   = longint'(aU) * longint'(bU);
            res = int'(p % MOD);
            co  = (p >= MOD);
            lat = W;
`else
            legal = 1'b0;
`endif
         end
         3'd4: begin
            if (aU >= HALF) begin
               res = (MOD - aU) % MOD;
               co  = (aU == 0);
               ovf = (aU == HALF);
            end else begin
               res = aU;
            end
            lat = 2;
         end
         default: legal = 1'b0;
      endcase
      if (legal) begin
         mOut = res[W-1:0];
         mCo  = co;
         mOvf = ovf;
         mZ   = (res == 0);
         mN   = (res >= HALF);
      end else begin
         lat = 1;
      end
      e.op  = op;
      e.out = mOut;
      e.co  = mCo;
      e.ovf = mOvf;
      e.z   = mZ;
      e.n   = mN;
      e.err = !legal;
      e.doneCyc = 0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (busy_o) begin
         checks++;
         failures++;
         $display("[TB] FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", n);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
      exp_t e;
      int   lat;
      waitIdle();
      if (track) begin
         computeExpect(op, a, b, e, lat);
         e.doneCyc = cyc + 1 + lat;
         expQ.push_back(e);
      end
      start_i = 1'b1;
      op_i    = op;
      data_i  = a;
      coef_i  = b;
      @(negedge clk_i);
      start_i = 1'b0;
      op_i    = 3'($urandom);
      data_i  = W'($urandom);
      coef_i  = W'($urandom);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_out"},  out_o, 0);
      checkOutput({tag, "_busy_done_err"}, {busy_o, done_o, err_o}, 0);
      checkOutput({tag, "_flags"}, {co_o, ovf_o, z_o, n_o}, 0);
   endtask

   // Monitor: every done pops the oldest expected completion.
   always @(negedge clk_i) begin
      exp_t e;
      if (err_o && !done_o) begin
         checks++;
         failures++;
         $display("[TB] FAIL err_without_done: err=1 done=0, expected err only with done");
      end
      if (done_o) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: done=1, expected no completion pending");
         end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("op%0d_out", e.op), out_o, e.out);
            checkOutput($sformatf("op%0d_co", e.op), co_o, e.co);
            checkOutput($sformatf("op%0d_ovf", e.op), ovf_o, e.ovf);
            checkOutput($sformatf("op%0d_z", e.op), z_o, e.z);
            checkOutput($sformatf("op%0d_n", e.op), n_o, e.n);
            checkOutput($sformatf("op%0d_err", e.op), err_o, e.err);
            checkOutput($sformatf("op%0d_busy_at_done", e.op), busy_o, 0);
            checkOutput($sformatf("op%0d_latency_cycle", e.op), cyc, e.doneCyc);
         end
      end
   end

   initial begin
      int n;
      logic [W-1:0] d;
      reset_i = 1'b0;
      start_i = 1'b0;
      op_i    = '0;
      data_i  = '0;
      coef_i  = '0;
      mOut = '0;
      mCo = 0; mOvf = 0; mZ = 0; mN = 0;
      repeat (2) @(negedge clk_i);
      checkResetState("reset");
      reset_i = 1'b1;

      applyStimulus(3'b000, 8'h05, 8'h00, 1);
      applyStimulus(3'b000, 8'h80, 8'h00, 1);
      applyStimulus(3'b000, 8'h00, 8'h00, 1);
      applyStimulus(3'b001, 8'h19, 8'h00, 1);
      applyStimulus(3'b001, 8'h1A, 8'h00, 1);
      applyStimulus(3'b010, 8'hA7, 8'h00, 1);
      applyStimulus(3'b100, 8'hF6, 8'h00, 1);
      applyStimulus(3'b100, 8'h12, 8'h00, 1);
      applyStimulus(3'b011, 8'h0D, 8'h0B, 1);
      applyStimulus(3'b011, 8'h20, 8'h10, 1);
      applyStimulus(3'b111, 8'h55, 8'h00, 1);
      applyStimulus(3'b101, 8'h01, 8'h00, 1);

      // A start pulse while running must neither restart nor add a completion.
      applyStimulus(3'b011, 8'hC3, 8'h5A, 1);
      start_i = 1'b1;
      op_i    = 3'b000;
      data_i  = 8'h33;
      @(negedge clk_i);
      start_i = 1'b0;

      // Abort a run with reset; the aborted op must not complete.
`ifdef SEQ_DATAPATH_MULC_EN
      applyStimulus(3'b011, 8'h77, 8'h99, 0);
`else
      applyStimulus(3'b010, 8'h77, 8'h00, 0);
`endif
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
      reset_i = 1'b1;
      mOut = '0;
      mCo = 0; mOvf = 0; mZ = 0; mN = 0;
      checkResetState("abort");
      applyStimulus(3'b000, 8'h05, 8'h00, 1);

      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
         case ($urandom_range(0, 5))
            0:       d = 8'h80;
            1:       d = 8'h00;
            2:       d = 8'hFF;
            default: d = W'($urandom);
         endcase
         applyStimulus(3'($urandom_range(0, 7)), d, W'($urandom), 1);
      end

      n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      repeat (3) @(negedge clk_i);
      checkOutput("pending_completions", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised multi-cycle arithmetic datapath with a start/busy/done handshake. It computes two's complement, ×10, upper-half duplicate, absolute value and an optional shift-add multiply by a run-time coefficient. All operands are latched at start, and the result and flags are held in a register until the next operation. It sits between the operand source and the result consumer as a self-sequenced block: callers issue one operation and wait for `done`, with no per-step control.

## Interface
- `W`, 8, datapath width; even, ≥4.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; accepted only in IDLE or DONE.
- `op`  in  3  operation select, sampled with `start`.
- `data`  in  W  operand A, sampled with `start`.
- `coef`  in  W  operand B (MULC only), sampled with `start`.
- `out`  out  W  result register.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `out` and flags valid.
- `err`  out  1  one-cycle pulse with `done` for an illegal op.
- `CO`, `OVF`, `Z`, `N`  out  1 each  registered flags of the last completed operation.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + `start` → RUN. Latch `op`, `data`, `coef`; clear the step counter.
  - RUN: one step per cycle. After the last step → DONE.
  - DONE → IDLE, unless `start` is high (back-to-back start allowed).
- Ops and step counts L:
  - 000 NEG, L=2: step 1 computes NOT A; step 2 adds 1. CO = carry of the +1. OVF = 1 iff A = 100…0.
  - 001 MUL10, L=2: step 1 computes A<<3; step 2 adds A<<1.
    - CO = 1 iff 10·A (unsigned) ≥ 2^W.
    - OVF = 1 iff 10·A (signed) falls outside [−2^(W−1), 2^(W−1)−1].
  - 010 DUP, L=3: result = {A[W−1:W/2], A[W−1:W/2]}. Computed as A>>W/2, then <<W/2, then OR with A>>W/2. CO = OVF = 0.
  - 011 MULC, L=W: shift-add over the W bits of `coef`, LSB first. `out` = low W bits of A·B (unsigned). CO = 1 iff any high product bit is nonzero. OVF = 0.
  - 100 ABS, L=2: if A[W−1] = 1, behaves as NEG including flags. Otherwise `out` = A, with CO = OVF = 0, after the same 2 cycles.
  - 101–111, or 011 when compiled out: illegal. L=1; `err` = 1; `out` and flags unchanged.
- Z = (`out` == 0), N = `out`[W−1]. Both are updated together with `out` when entering DONE.
- Intermediate values live in an internal working register; `out` and flags change only on entry to DONE.

## Timing
- Reset (`reset` = 0 at an edge): `out` = 0, CO = OVF = Z = N = 0, `busy` = `done` = `err` = 0, state IDLE. Takes priority over everything, including a RUN in progress; the aborted op produces no `done`.
- `start` accepted at edge T0:
  - `busy` = 1 from after T0 until after edge T0+L.
  - After edge T0+L: `busy` = 0, `done` = 1 for exactly one cycle, `out` and flags valid.
- `start` during RUN is ignored. Changes to `op`, `data`, `coef` during RUN have no effect.
- `start` in DONE: new op accepted, `done` drops next cycle, `busy` rises, previous `out` is held until the new completion.
- `done` and `busy` are never high together.

## Configuration
- `SEQ_DATAPATH_MULC_EN`
  - Defined: op 011 MULC is implemented, along with its W-cycle iteration counter and coefficient shift register.
  - Undefined: the MULC logic is removed and op 011 behaves as an illegal op (L=1, `err` pulse, `out` unchanged).
  - All other ops are identical in both builds.

## Test plan
- W=8, NEG, `data` = 0x05 → `done` 2 cycles after start, `out` = 0xFB, N=1, CO=0, OVF=0. `data` = 0x80 → `out` = 0x80, OVF=1. `data` = 0x00 → `out` = 0x00, Z=1, CO=1.
- MUL10:
  - `data` = 0x19 → `out` = 0xFA, CO=0, OVF=1.
  - `data` = 0x1A → `out` = 0x04, CO=1.
  - Latency 2 in both cases.
- DUP, `data` = 0xA7 → `out` = 0xAA after 3 cycles. ABS, `data` = 0xF6 → `out` = 0x0A, N=0. ABS, `data` = 0x12 → `out` = 0x12 after 2 cycles.
- MULC (macro defined):
  - 0x0D × 0x0B → `out` = 0x8F, CO=0, `done` 8 cycles after start.
  - 0x20 × 0x10 → `out` = 0x00, CO=1, Z=1.
  - Macro undefined: op 011 → `err` = 1 after 1 cycle, `out` unchanged.
- Handshake:
  - `start` pulsed during a MULC → ignored; one `done` only.
  - Back-to-back start in DONE → second op completes correctly.
  - Op 111 → `err` and `done` together for one cycle.
- `reset` = 0 at the 4th cycle of MULC → after that edge `busy` = 0, `out` = 0, all flags 0, no `done`. A subsequent NEG completes normally.
